// File: rtl/tl_fsm_w_left.sv
// Traffic-light state register and next-state logic with left-turn phases.
// Eight phases, dwell counter for green/yellow/left timing, and per-street left-request latches.

module tl_lreq_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic lreq
);
  // Clear wins so a request seen in the cycle entering the left phase is absorbed by it.
  always_ff @(posedge clk) begin
    if (!reset_n)  lreq <= 1'b0;
    else if (clr)  lreq <= 1'b0;
    else if (set)  lreq <= 1'b1;
  end
endmodule

module tl_fsm_w_left #(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int LEFT_MAX   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Tal,
  input  logic       Tbl,
  output logic [2:0] q,
  output logic       chg
);
  localparam int NUM_DIRS = 2;
  localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] YCYC_M1 = 8'(YELLOW_CYC - 1);
  localparam logic [7:0] LMAX_M1 = 8'(LEFT_MAX - 1);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A left-yellow
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B left-yellow
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic [NUM_DIRS-1:0] lreq, lreq_set, lreq_clr;

  assign lreq_set = {Tbl, Tal};
  assign lreq_clr = {(state_nxt == S6) && (state != S6),
                     (state_nxt == S2) && (state != S2)};

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    tl_lreq_latch u_lreq (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (lreq_set[d]),
      .clr     (lreq_clr[d]),
      .lreq    (lreq[d])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S0: if (cnt >= GMIN_M1 && !Ta)    state_nxt = S1;
      S1: if (cnt == YCYC_M1)           state_nxt = (lreq[0] | Tal) ? S2 : S4;
      S2: if (!Tal || cnt >= LMAX_M1)   state_nxt = S3;
      S3: if (cnt == YCYC_M1)           state_nxt = S4;
      S4: if (cnt >= GMIN_M1 && !Tb)    state_nxt = S5;
      S5: if (cnt == YCYC_M1)           state_nxt = (lreq[1] | Tbl) ? S6 : S0;
      S6: if (!Tbl || cnt >= LMAX_M1)   state_nxt = S7;
      S7: if (cnt == YCYC_M1)           state_nxt = S0;
      default:                          state_nxt = S0;
    endcase
  end

  // Dwell counter restarts on every state change and saturates so long greens never wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S0;
      cnt   <= '0;
      chg   <= 1'b0;
    end else begin
      state <= state_nxt;
      chg   <= (state_nxt != state);
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
    end
  end

  assign q = state;
endmodule

// File: tb/tb_tl_fsm_w_left.sv
// Bench for tl_fsm_w_left: directed phase sequences plus randomized run against a phase-level model.

module tb_tl_fsm_w_left;
  localparam int GREEN_MIN  = 4;
  localparam int YELLOW_CYC = 2;
  localparam int LEFT_MAX   = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Ta = 1'b0, Tb = 1'b0, Tal = 1'b0, Tbl = 1'b0;
  logic [2:0] q;
  logic       chg;

  int n_checks = 0;
  int n_errors = 0;

  // Model: direction (0=A,1=B), step within direction (0 green,1 yellow,2 left,3 left-yellow)
  int m_dir = 0, m_step = 0, m_dwell = 0;
  bit m_req[2];
  bit m_chg = 1'b0;

  tl_fsm_w_left #(.GREEN_MIN(GREEN_MIN), .YELLOW_CYC(YELLOW_CYC), .LEFT_MAX(LEFT_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tb(Tb), .Tal(Tal), .Tbl(Tbl), .q(q), .chg(chg)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_q();
    return 3'(m_dir * 4 + m_step);
  endfunction

  function automatic void model_update(input bit ta, tb, tal, tbl, rn);
    bit t[2];
    bit tl[2];
    int nd, ns;
    if (!rn) begin
      m_dir = 0; m_step = 0; m_dwell = 0; m_req[0] = 0; m_req[1] = 0; m_chg = 0;
      return;
    end
    t[0] = ta; t[1] = tb; tl[0] = tal; tl[1] = tbl;
    nd = m_dir; ns = m_step;
    case (m_step)
      0: if (m_dwell >= GREEN_MIN - 1 && !t[m_dir]) ns = 1;
      1: if (m_dwell == YELLOW_CYC - 1) begin
           if (m_req[m_dir] || tl[m_dir]) ns = 2;
           else begin ns = 0; nd = 1 - m_dir; end
         end
      2: if (!tl[m_dir] || m_dwell >= LEFT_MAX - 1) ns = 3;
      default: if (m_dwell == YELLOW_CYC - 1) begin ns = 0; nd = 1 - m_dir; end
    endcase
    m_req[0] |= tal;
    m_req[1] |= tbl;
    if (ns == 2 && m_step != 2) m_req[nd] = 0;
    m_chg   = (nd != m_dir) || (ns != m_step);
    m_dwell = m_chg ? 0 : m_dwell + 1;
    m_dir   = nd;
    m_step  = ns;
  endfunction

  task automatic step(input bit ta, tb, tal, tbl, rn);
    Ta = ta; Tb = tb; Tal = tal; Tbl = tbl; reset_n = rn;
    @(posedge clk);
    model_update(ta, tb, tal, tbl, rn);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd1) begin
      n_errors++; $display("FAIL reset_pre: q=%0d expected 1", q);
    end
    do_reset();
    n_checks++;
    if (q !== 3'd0 || chg !== 1'b0) begin
      n_errors++; $display("FAIL reset: q=%0d chg=%0b expected q=0 chg=0", q, chg);
    end
  endtask

  task automatic test_idle();
    byte exp_seq[24] = '{0,0,0,1,1,4,4,4,4,5,5,0, 0,0,0,1,1,4,4,4,4,5,5,0};
    byte prev = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (q !== exp_seq[i][2:0] || chg !== (exp_seq[i] != prev)) begin
        n_errors++;
        $display("FAIL idle[%0d]: q=%0d chg=%0b expected q=%0d chg=%0b",
                 i, q, chg, exp_seq[i], exp_seq[i] != prev);
      end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_ta_hold();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 1);
      n_checks++;
      if (q !== 3'd0) begin
        n_errors++; $display("FAIL ta_hold[%0d]: q=%0d expected 0", i, q);
      end
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd1 || chg !== 1'b1) begin
      n_errors++; $display("FAIL ta_release: q=%0d chg=%0b expected q=1 chg=1", q, chg);
    end
    // Hold exactly long enough that a wrapping counter would read 0 at release.
    do_reset();
    for (int i = 0; i < 256; i++) step(1, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd0) begin
      n_errors++; $display("FAIL ta_long_hold: q=%0d expected 0", q);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd1) begin
      n_errors++; $display("FAIL cnt_saturate: q=%0d expected 1", q);
    end
  endtask

  task automatic test_tal_pulse();
    byte exp_seq[9] = '{0,0,0,1,1,2,3,3,4};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(0, 0, (i == 1), 0, 1);
      n_checks++;
      if (q !== exp_seq[i][2:0]) begin
        n_errors++; $display("FAIL tal_pulse[%0d]: q=%0d expected %0d", i, q, exp_seq[i]);
      end
    end
    // Latch was consumed by S2, so the next A yellow goes straight to B green.
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd4) begin
      n_errors++; $display("FAIL tal_consumed: q=%0d expected 4", q);
    end
  endtask

  task automatic test_tbl_hold();
    int run = 0;
    int runs = 0;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 0, 1, 1);
      n_checks++;
      if (q !== m_q() || chg !== m_chg) begin
        n_errors++;
        $display("FAIL tbl_hold[%0d]: q=%0d chg=%0b expected q=%0d chg=%0b", i, q, chg, m_q(), m_chg);
      end
      if (q === 3'd6) run++;
      else if (run != 0) begin
        runs++;
        n_checks++;
        if (run != LEFT_MAX || q !== 3'd7) begin
          n_errors++; $display("FAIL tbl_left_len: len=%0d next q=%0d expected len=%0d next 7", run, q, LEFT_MAX);
        end
        run = 0;
      end
    end
    n_checks++;
    if (runs < 2) begin
      n_errors++; $display("FAIL tbl_runs: saw %0d B left phases expected >=2", runs);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, (i == 7), 0, 1);
    n_checks++;
    if (q !== 3'd5) begin
      n_errors++; $display("FAIL reset_mid_pre: q=%0d expected 5", q);
    end
    do_reset();
    n_checks++;
    if (q !== 3'd0 || chg !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid: q=%0d chg=%0b expected q=0 chg=0", q, chg);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd4) begin
      n_errors++; $display("FAIL reset_clears_lreq: q=%0d expected 4", q);
    end
  endtask

  task automatic test_tal_last_yellow();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd1) begin
      n_errors++; $display("FAIL tal_late_pre: q=%0d expected 1", q);
    end
    step(0, 0, 1, 0, 1);
    n_checks++;
    if (q !== 3'd2) begin
      n_errors++; $display("FAIL tal_late_enter: q=%0d expected 2", q);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (q !== 3'd3) begin
      n_errors++; $display("FAIL tal_late_exit: q=%0d expected 3", q);
    end
  endtask

  task automatic test_random();
    bit ta, tb, tal, tbl, rn;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      ta  = ($urandom_range(0, 3) != 0) ? (i % 40 < 20) : 1'b0;
      tb  = ($urandom_range(0, 2) == 0);
      tal = ($urandom_range(0, 9) == 0);
      tbl = ($urandom_range(0, 4) == 0) ? 1'b1 : ((i / 50) % 3 == 0);
      rn  = ($urandom_range(0, 299) != 0);
      step(ta, tb, tal, tbl, rn);
      n_checks++;
      if (q !== m_q() || chg !== m_chg) begin
        n_errors++;
        $display("FAIL random[%0d]: q=%0d chg=%0b expected q=%0d chg=%0b", i, q, chg, m_q(), m_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ta_hold();
    test_tal_pulse();
    test_tbl_hold();
    test_reset_mid();
    test_tal_last_yellow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
